fifo_1w_2r: RTL and testbench

FIFO_1W_2R -- requirements
Module: fifo_1w_2r

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_ptr_step.sv | 33 +++
 rtl/fifo_1w_2r.sv | 118 +++++++++++
 tb/tb_fifo_1w_2r.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and pop classification for the dual-read FIFO
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 65;
  localparam int DEFAULT_ADDRESS_WIDTH = 3;

  // Encoding equals the read pointer step, so it feeds fifo_ptr_step directly.
  typedef enum logic [1:0] {
    POP_NONE   = 2'd0,
    POP_SINGLE = 2'd1,
    POP_PAIR   = 2'd2
  } pop_e;

  function automatic pop_e pop_kind(input logic rd_req, input logic stall,
                                    input logic drain, input logic has_pair,
                                    input logic has_one);
    pop_e kind;
    kind = POP_NONE;
    if (rd_req && !stall) begin
      if (has_pair) kind = POP_PAIR;
      else if (has_one && drain) kind = POP_SINGLE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/fifo_ptr_step.sv
// rtl/fifo_ptr_step.sv - binary pointer advancing by 0/1/2 modulo FIFO_DEPTH
module fifo_ptr_step #(
  parameter int ADDRESS_WIDTH = 3,
  parameter int FIFO_DEPTH    = (1 << ADDRESS_WIDTH)
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic [1:0]               step,
  output logic [ADDRESS_WIDTH-1:0] ptr
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH+1)'(FIFO_DEPTH);

  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDRESS_WIDTH:0]   sum;
  logic [ADDRESS_WIDTH:0]   wrapped;

  // One extra bit holds ptr+step before the modulo fold.
  always_comb begin
    sum     = {1'b0, ptr_q} + (ADDRESS_WIDTH+1)'(step);
    wrapped = sum;
    if (sum >= DEPTH_W) wrapped = sum - DEPTH_W;
    ptr_d   = wrapped[ADDRESS_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (clear) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_1w_2r.sv
// rtl/fifo_1w_2r.sv - one-write, pair-read FIFO with single-word drain
module fifo_1w_2r
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int FIFO_DEPTH    = (1 << ADDRESS_WIDTH)
) (
  input  logic                   Clk,
  input  logic                   Clear_in,
  input  logic [DATA_WIDTH-1:0]  Data_in,
  input  logic                   WriteEn_in,
  output logic                   Full_out,
  output logic                   Overflow_out,
  input  logic                   stall,
  input  logic                   ReadEn_in,
  input  logic                   Drain_in,
  output logic [DATA_WIDTH-1:0]  Data_out_1,
  output logic [DATA_WIDTH-1:0]  Data_out_2,
  output logic                   Data_valid,
  output logic                   Second_valid,
  output logic                   Empty_out,
  output logic [ADDRESS_WIDTH:0] Count_out
);

  localparam logic [ADDRESS_WIDTH:0]   DEPTH_W  = (ADDRESS_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic [ADDRESS_WIDTH:0]   count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]    data_out_1_q, data_out_1_d;
  logic [DATA_WIDTH-1:0]    data_out_2_q, data_out_2_d;
  logic                     data_valid_q, data_valid_d;
  logic                     second_valid_q, second_valid_d;
  logic                     full, wr_en;
  logic [1:0]               wr_step, rd_step;
  pop_e                     pop;

  // All decisions use pre-edge occupancy, so a word written this cycle cannot be popped until the next.
  assign full        = (count_q == DEPTH_W);
  assign wr_en       = WriteEn_in && !full;
  assign pop         = pop_kind(ReadEn_in, stall, Drain_in, count_q >= 2, count_q == 1);
  assign wr_step     = {1'b0, wr_en};
  assign rd_step     = pop;
  assign rd_ptr_next = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;

  fifo_ptr_step #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_wr_ptr (
    .clk  (Clk),
    .clear(Clear_in),
    .step (wr_step),
    .ptr  (wr_ptr)
  );

  fifo_ptr_step #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rd_ptr (
    .clk  (Clk),
    .clear(Clear_in),
    .step (rd_step),
    .ptr  (rd_ptr)
  );

  always_comb begin
    count_d        = count_q + (ADDRESS_WIDTH+1)'(wr_en) - (ADDRESS_WIDTH+1)'(rd_step);
    overflow_d     = overflow_q || (WriteEn_in && full);
    data_out_1_d   = data_out_1_q;
    data_out_2_d   = data_out_2_q;
    data_valid_d   = 1'b0;
    second_valid_d = 1'b0;
    case (pop)
      POP_PAIR: begin
        data_out_1_d   = mem_q[rd_ptr];
        data_out_2_d   = mem_q[rd_ptr_next];
        data_valid_d   = 1'b1;
        second_valid_d = 1'b1;
      end
      POP_SINGLE: begin
        data_out_1_d = mem_q[rd_ptr];
        data_out_2_d = '0;
        data_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      count_q        <= '0;
      overflow_q     <= 1'b0;
      data_out_1_q   <= '0;
      data_out_2_q   <= '0;
      data_valid_q   <= 1'b0;
      second_valid_q <= 1'b0;
    end else begin
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      data_out_1_q   <= data_out_1_d;
      data_out_2_q   <= data_out_2_d;
      data_valid_q   <= data_valid_d;
      second_valid_q <= second_valid_d;
    end
  end

  // Storage is deliberately left out of the clear; stale words are unreachable once pointers reset.
  always_ff @(posedge Clk) begin
    if (wr_en && !Clear_in) mem_q[wr_ptr] <= Data_in;
  end

  assign Full_out     = full;
  assign Empty_out    = (count_q < 2);
  assign Count_out    = count_q;
  assign Overflow_out = overflow_q;
  assign Data_out_1   = data_out_1_q;
  assign Data_out_2   = data_out_2_q;
  assign Data_valid   = data_valid_q;
  assign Second_valid = second_valid_q;

endmodule

// File: tb/tb_fifo_1w_2r.sv
// tb/tb_fifo_1w_2r.sv - randomized and directed bench for fifo_1w_2r against a queue model
module tb_fifo_1w_2r;

  localparam int DW    = 65;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          Clk = 1'b0;
  logic          Clear_in = 1'b1;
  logic [DW-1:0] Data_in = '0;
  logic          WriteEn_in = 1'b0;
  logic          Full_out, Overflow_out;
  logic          stall = 1'b0;
  logic          ReadEn_in = 1'b0;
  logic          Drain_in = 1'b0;
  logic [DW-1:0] Data_out_1, Data_out_2;
  logic          Data_valid, Second_valid, Empty_out;
  logic [AW:0]   Count_out;

  always #5 Clk = ~Clk;

  fifo_1w_2r #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Clear_in(Clear_in), .Data_in(Data_in), .WriteEn_in(WriteEn_in),
    .Full_out(Full_out), .Overflow_out(Overflow_out), .stall(stall),
    .ReadEn_in(ReadEn_in), .Drain_in(Drain_in), .Data_out_1(Data_out_1),
    .Data_out_2(Data_out_2), .Data_valid(Data_valid), .Second_valid(Second_valid),
    .Empty_out(Empty_out), .Count_out(Count_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] m_q[$];
  logic          exp_over = 1'b0, exp_v1 = 1'b0, exp_v2 = 1'b0;
  logic [DW-1:0] exp_d1 = '0, exp_d2 = '0;

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Drives one clock of stimulus and advances the queue model; returns at edge+1.
  task automatic drive_cycle(input logic we, input logic [DW-1:0] din, input logic re,
                             input logic drain, input logic st, input logic clr);
    int pre;
    WriteEn_in = we; Data_in = din; ReadEn_in = re; Drain_in = drain; stall = st; Clear_in = clr;
    pre = m_q.size();
    @(posedge Clk);
    exp_v1 = 1'b0;
    exp_v2 = 1'b0;
    if (clr) begin
      m_q.delete();
      exp_over = 1'b0; exp_d1 = '0; exp_d2 = '0;
    end else begin
      if (re && !st && pre >= 2) begin
        exp_d1 = m_q.pop_front(); exp_d2 = m_q.pop_front(); exp_v1 = 1'b1; exp_v2 = 1'b1;
      end else if (re && !st && drain && pre == 1) begin
        exp_d1 = m_q.pop_front(); exp_d2 = '0; exp_v1 = 1'b1;
      end
      if (we) begin
        if (pre == DEPTH) exp_over = 1'b1;
        else m_q.push_back(din);
      end
    end
    #1;
    WriteEn_in = 1'b0; ReadEn_in = 1'b0; Drain_in = 1'b0; stall = 1'b0; Clear_in = 1'b0;
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, rand_word(), 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++; if (Count_out !== 4'd0) $display("FAIL reset_count got %0d want 0", Count_out); else n_pass++;
    n_checks++; if ({Empty_out, Full_out, Overflow_out, Data_valid, Second_valid} !== 5'b10000)
      $display("FAIL reset_flags got %b want 10000", {Empty_out, Full_out, Overflow_out, Data_valid, Second_valid}); else n_pass++;
    n_checks++; if ({Data_out_1, Data_out_2} !== '0) $display("FAIL reset_data got %h/%h want 0/0", Data_out_1, Data_out_2); else n_pass++;
  endtask

  task automatic test_pairs();
    for (int i = 1; i <= 4; i++) drive_cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (Count_out !== 4'd4) $display("FAIL pairs_count4 got %0d want 4", Count_out); else n_pass++;
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({Data_valid, Second_valid, Data_out_1, Data_out_2, Count_out} !== {2'b11, DW'(1), DW'(2), 4'd2})
      $display("FAIL pairs_first got v=%b%b %0d,%0d cnt %0d want v=11 1,2 cnt 2", Data_valid, Second_valid, Data_out_1, Data_out_2, Count_out); else n_pass++;
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({Data_valid, Second_valid, Data_out_1, Data_out_2, Count_out, Empty_out} !== {2'b11, DW'(3), DW'(4), 4'd0, 1'b1})
      $display("FAIL pairs_second got v=%b%b %0d,%0d cnt %0d e=%b want v=11 3,4 cnt 0 e=1", Data_valid, Second_valid, Data_out_1, Data_out_2, Count_out, Empty_out); else n_pass++;
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({Data_valid, Second_valid, Data_out_1, Data_out_2} !== {2'b00, DW'(3), DW'(4)})
      $display("FAIL pairs_hold got v=%b%b %0d,%0d want v=00 3,4", Data_valid, Second_valid, Data_out_1, Data_out_2); else n_pass++;
  endtask

  task automatic test_full_overflow();
    logic [DW-1:0] a[DEPTH];
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      a[i] = rand_word();
      drive_cycle(1'b1, a[i], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    n_checks++; if ({Full_out, Overflow_out, Count_out} !== {2'b10, 4'd8}) $display("FAIL full_set got f=%b o=%b cnt %0d want f=1 o=0 cnt 8", Full_out, Overflow_out, Count_out); else n_pass++;
    drive_cycle(1'b1, rand_word(), 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({Full_out, Overflow_out, Count_out} !== {2'b11, 4'd8}) $display("FAIL overflow_set got f=%b o=%b cnt %0d want f=1 o=1 cnt 8", Full_out, Overflow_out, Count_out); else n_pass++;
    for (int i = 0; i < DEPTH; i += 2) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++; if ({Data_valid, Second_valid, Data_out_1, Data_out_2} !== {2'b11, a[i], a[i+1]})
        $display("FAIL full_order pair %0d got %h,%h want %h,%h", i, Data_out_1, Data_out_2, a[i], a[i+1]); else n_pass++;
    end
    n_checks++; if ({Overflow_out, Empty_out, Count_out} !== {2'b11, 4'd0}) $display("FAIL overflow_sticky got o=%b e=%b cnt %0d want o=1 e=1 cnt 0", Overflow_out, Empty_out, Count_out); else n_pass++;
  endtask

  task automatic test_drain();
    logic [DW-1:0] w[5];
    logic [DW-1:0] b[4];
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      w[i] = rand_word();
      drive_cycle(1'b1, w[i], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({Count_out, Empty_out} !== {4'd1, 1'b1}) $display("FAIL drain_one_left got cnt %0d e=%b want cnt 1 e=1", Count_out, Empty_out); else n_pass++;
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({Data_valid, Count_out} !== {1'b0, 4'd1}) $display("FAIL drain_nodrain got v=%b cnt %0d want v=0 cnt 1", Data_valid, Count_out); else n_pass++;
    drive_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++; if ({Data_valid, Second_valid, Data_out_1, Data_out_2, Count_out} !== {2'b10, w[4], DW'(0), 4'd0})
      $display("FAIL drain_single got v=%b%b %h,%h cnt %0d want v=10 %h,0 cnt 0", Data_valid, Second_valid, Data_out_1, Data_out_2, Count_out, w[4]); else n_pass++;
    // Read pointer now sits on an odd slot; the second pair below straddles the last slot and slot 0.
    for (int i = 0; i < 4; i++) begin
      b[i] = rand_word();
      drive_cycle(1'b1, b[i], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i += 2) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++; if ({Data_valid, Second_valid, Data_out_1, Data_out_2} !== {2'b11, b[i], b[i+1]})
        $display("FAIL odd_wrap pair %0d got %h,%h want %h,%h", i, Data_out_1, Data_out_2, b[i], b[i+1]); else n_pass++;
    end
  endtask

  task automatic test_simul_stall();
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, rand_word(), 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, rand_word(), 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({Count_out, Data_valid, Second_valid, Data_out_1, Data_out_2} !== {4'd5, 2'b11, exp_d1, exp_d2})
      $display("FAIL simul_wr_rd got cnt %0d v=%b%b want cnt 5 v=11", Count_out, Data_valid, Second_valid); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, rand_word(), 1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++; if ({Count_out, Data_valid} !== {4'(6 + i), 1'b0}) $display("FAIL stall_step %0d got cnt %0d v=%b want cnt %0d v=0", i, Count_out, Data_valid, 6 + i); else n_pass++;
    end
    n_checks++; if ({Full_out, Empty_out} !== 2'b10) $display("FAIL stall_full got f=%b e=%b want f=1 e=0", Full_out, Empty_out); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] sent[$];
    logic [DW-1:0] got[$];
    int written = 0;
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 300; cyc++) begin
      logic we;
      logic [DW-1:0] wd;
      we = (written < 20) && ($urandom_range(0, 3) != 0);
      wd = rand_word();
      if (we && Count_out != 4'd8) begin sent.push_back(wd); written++; end
      drive_cycle(we, wd, $urandom_range(0, 1) == 1, written == 20, 1'b0, 1'b0);
      if (Data_valid) got.push_back(Data_out_1);
      if (Second_valid) got.push_back(Data_out_2);
      if (written == 20 && m_q.size() == 0 && got.size() == 20) break;
    end
    n_checks++; if (got.size() != 20 || sent.size() != 20) $display("FAIL wrap_total got %0d sent %0d want 20/20", got.size(), sent.size()); else n_pass++;
    for (int i = 0; i < 20 && i < got.size() && i < sent.size(); i++) begin
      n_checks++; if (got[i] !== sent[i]) $display("FAIL wrap_order idx %0d got %h want %h", i, got[i], sent[i]); else n_pass++;
    end
  endtask

  task automatic test_clear();
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) drive_cycle(1'b1, rand_word(), 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({Count_out, Overflow_out, Data_valid} !== {4'd6, 2'b11}) $display("FAIL clear_pre got cnt %0d o=%b v=%b want cnt 6 o=1 v=1", Count_out, Overflow_out, Data_valid); else n_pass++;
    drive_cycle(1'b1, rand_word(), 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++; if ({Data_valid, Second_valid, Count_out, Overflow_out, Empty_out, Full_out} !== {2'b00, 4'd0, 3'b010})
      $display("FAIL clear_mid got v=%b%b cnt %0d o=%b e=%b f=%b want v=00 cnt 0 o=0 e=1 f=0", Data_valid, Second_valid, Count_out, Overflow_out, Empty_out, Full_out); else n_pass++;
    n_checks++; if ({Data_out_1, Data_out_2} !== '0) $display("FAIL clear_data got %h/%h want 0/0", Data_out_1, Data_out_2); else n_pass++;
  endtask

  task automatic test_random();
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive_cycle($urandom_range(0, 2) != 0, rand_word(), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
      n_checks++;
      if ({Count_out, Full_out, Empty_out, Overflow_out, Data_valid, Second_valid} !==
          {4'(m_q.size()), m_q.size() == DEPTH, m_q.size() < 2, exp_over, exp_v1, exp_v2})
        $display("FAIL rnd_flags cyc %0d got cnt %0d f%b e%b o%b v%b%b want cnt %0d o%b v%b%b", cyc, Count_out,
                 Full_out, Empty_out, Overflow_out, Data_valid, Second_valid, m_q.size(), exp_over, exp_v1, exp_v2);
      else n_pass++;
      n_checks++;
      if ({Data_out_1, Data_out_2} !== {exp_d1, exp_d2})
        $display("FAIL rnd_data cyc %0d got %h,%h want %h,%h", cyc, Data_out_1, Data_out_2, exp_d1, exp_d2);
      else n_pass++;
    end
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    test_reset();
    test_pairs();
    test_full_overflow();
    test_drain();
    test_simul_stall();
    test_wrap();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
